// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops a 1-cycle-latency FIFO, packs N words per valid/ready beat, flushes partial beats with a keep mask
module fifo_rd_packer #(
  parameter int DW = 16,
  parameter int N  = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fifo_re,
  input  logic [DW-1:0]   fifo_dout,
  input  logic            fifo_valid,
  input  logic            fifo_empty,
  input  logic            fifo_under,
  input  logic            flush,
  output logic [N*DW-1:0] m_data,
  output logic [N-1:0]    m_keep,
  output logic            m_valid,
  output logic            m_last,
  input  logic            m_ready,
  output logic            busy,
  output logic            err_under
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {RUN, FLUSH_WAIT, FLUSH_EMIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic inflight_q, inflight_d;
  logic [N*DW-1:0] accum_q, accum_d, m_data_q, m_data_d, part_data;
  logic [N-1:0] m_keep_q, m_keep_d, part_keep;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, err_under_q, err_under_d;
  logic capture, out_free, full_load, part_load;
  always_comb begin
    capture = fifo_valid && inflight_q;
    out_free = !m_valid_q || m_ready;
    accum_d = accum_q;
    part_keep = '0;
    part_data = '0;
    for (int k = 0; k < N; k++) begin
      if (capture && cnt_q == CW'(k)) accum_d[k*DW +: DW] = fifo_dout;
      part_keep[k] = CW'(k) < cnt_q;
      if (part_keep[k]) part_data[k*DW +: DW] = accum_q[k*DW +: DW];
    end
    // the word arriving this cycle completes the beat and is merged into it
    full_load = out_free && (cnt_q == CW'(N) || (cnt_q == CW'(N - 1) && capture));
    part_load = state_q == FLUSH_EMIT && out_free && cnt_q != '0;
    fifo_re = rst && state_q == RUN && !fifo_empty && !flush && (cnt_q + CW'(inflight_q) < CW'(N));
    inflight_d = fifo_re;
    cnt_d = (full_load || part_load) ? '0 : cnt_q + CW'(capture);
    m_valid_d = full_load || part_load || (m_valid_q && !m_ready);
    m_data_d = full_load ? accum_d : part_load ? part_data : m_data_q;
    m_keep_d = full_load ? '1 : part_load ? part_keep : m_keep_q;
    m_last_d = full_load ? 1'b0 : part_load ? 1'b1 : m_last_q;
    err_under_d = err_under_q || fifo_under;
    state_d = state_q == RUN ? (flush ? FLUSH_WAIT : RUN) :
              state_q == FLUSH_WAIT ? ((!inflight_q && cnt_q != CW'(N)) ? FLUSH_EMIT : FLUSH_WAIT) :
              (out_free ? RUN : FLUSH_EMIT);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      inflight_q <= 1'b0;
      accum_q <= '0;
      m_data_q <= '0;
      m_keep_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      inflight_q <= inflight_d;
      accum_q <= accum_d;
      m_data_q <= m_data_d;
      m_keep_q <= m_keep_d;
      m_valid_q <= m_valid_d;
      m_last_q <= m_last_d;
      err_under_q <= err_under_d;
    end
  end
  assign m_data = m_data_q;
  assign m_keep = m_keep_q;
  assign m_valid = m_valid_q;
  assign m_last = m_last_q;
  assign err_under = err_under_q;
  assign busy = state_q != RUN || cnt_q != '0 || inflight_q || m_valid_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed and randomized checks of fifo_rd_packer against a word-stream reference model
module tb_fifo_rd_packer;
  localparam int DW = 16;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fifo_re, fifo_valid, fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic fifo_under = 1'b0;
  logic flush = 1'b0;
  logic m_ready = 1'b0;
  logic [N*DW-1:0] m_data;
  logic [N-1:0] m_keep;
  logic m_valid, m_last, busy, err_under;
  int cmp = 0;
  int errs = 0;
  int got_rd = 0;

  fifo_rd_packer #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst(rst), .fifo_re(fifo_re), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
    .fifo_empty(fifo_empty), .fifo_under(fifo_under), .flush(flush), .m_data(m_data),
    .m_keep(m_keep), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .err_under(err_under)
  );

  always #5 clk = ~clk;

  // FIFO model with one cycle of read latency; force_* injects stray valid data
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic mv = 1'b0;
  logic [DW-1:0] md = '0;
  logic force_valid = 1'b0;
  logic [DW-1:0] force_data = '0;
  assign fifo_empty = rd_ptr == wr_ptr;
  assign fifo_valid = mv || force_valid;
  assign fifo_dout = force_valid ? force_data : md;
  always @(posedge clk) begin
    mv <= 1'b0;
    if (fifo_re && !fifo_empty) begin
      md <= mem[rd_ptr[7:0]];
      mv <= 1'b1;
      rd_ptr <= rd_ptr + 1;
    end
  end

  // monitor: accepted beats, pop count, protocol violations
  int pops = 0;
  int re_bad = 0;
  int hold_bad = 0;
  int got_n = 0;
  logic [N*DW-1:0] got_data [0:1023];
  logic [N-1:0] got_keep [0:1023];
  logic got_last [0:1023];
  logic stall = 1'b0;
  logic [N*DW-1:0] h_data = '0;
  logic [N-1:0] h_keep = '0;
  logic h_last = 1'b0;
  always @(negedge clk) begin
    if (fifo_re) pops <= pops + 1;
    if (fifo_re && fifo_empty) re_bad <= re_bad + 1;
    if (stall && (!m_valid || m_data !== h_data || m_keep !== h_keep || m_last !== h_last)) hold_bad <= hold_bad + 1;
    if (rst && m_valid && m_ready) begin
      got_data[got_n[9:0]] <= m_data;
      got_keep[got_n[9:0]] <= m_keep;
      got_last[got_n[9:0]] <= m_last;
      got_n <= got_n + 1;
    end
    stall <= rst && m_valid && !m_ready;
    h_data <= m_data;
    h_keep <= m_keep;
    h_last <= m_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_beats(input int n, input bit rnd, output bit ok, output int used);
    ok = 1'b0;
    used = 0;
    for (int t = 0; t < 400 && !ok; t++) begin
      if (rnd) m_ready = 1'($urandom);
      tick();
      used++;
      ok = got_n - got_rd >= n;
    end
  endtask

  task automatic test_reset();
    m_ready = 1'b0;
    force_valid = 1'b1;
    force_data = 16'hbeef;
    rst = 1'b0;
    repeat (2) tick();
    cmp++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_keep !== '0) begin
      errs++;
      $display("FAIL reset_ctrl: valid=%b last=%b keep=%b, want 0 0 00", m_valid, m_last, m_keep);
    end
    cmp++;
    if (m_data !== '0) begin errs++; $display("FAIL reset_data: got %h want 0", m_data); end
    cmp++;
    if (busy !== 1'b0 || err_under !== 1'b0 || fifo_re !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: busy=%b err_under=%b fifo_re=%b, want 0 0 0", busy, err_under, fifo_re);
    end
    rst = 1'b1;
    tick();
    force_valid = 1'b0;
    cmp++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_no_capture: busy=%b want 0", busy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_flush_empty: m_valid=%b busy=%b want 0 0", m_valid, busy);
    end
  endtask

  task automatic test_stream();
    bit ok;
    int used, p0;
    logic [N*DW-1:0] exp;
    got_rd = got_n;
    m_ready = 1'b1;
    p0 = pops;
    for (int i = 1; i <= 4; i++) push(16'(i));
    wait_beats(2, 1'b0, ok, used);
    cmp++;
    if (!ok || used > 7) begin errs++; $display("FAIL stream_latency: ok=%b cycles=%0d want <=7", ok, used); end
    for (int b = 0; b < 2; b++) begin
      exp = {16'(2 * b + 2), 16'(2 * b + 1)};
      cmp++;
      if (got_data[got_rd] !== exp || got_keep[got_rd] !== 2'b11 || got_last[got_rd] !== 1'b0) begin
        errs++;
        $display("FAIL stream_beat%0d: got %h/%b/%b want %h/11/0", b, got_data[got_rd], got_keep[got_rd], got_last[got_rd], exp);
      end
      got_rd++;
    end
    for (int t = 0; t < 50 && busy; t++) tick();
    cmp++;
    if (busy !== 1'b0 || pops - p0 != 4 || re_bad != 0) begin
      errs++;
      $display("FAIL stream_idle: busy=%b pops=%0d re_when_empty=%0d want 0 4 0", busy, pops - p0, re_bad);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int used, p0;
    logic [N*DW-1:0] exp;
    got_rd = got_n;
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 6; i++) push(16'(i));
    repeat (20) tick();
    cmp++;
    if (m_valid !== 1'b1 || m_data !== 32'h0002_0001) begin
      errs++;
      $display("FAIL bp_hold: valid=%b data=%h want 1 00020001", m_valid, m_data);
    end
    cmp++;
    if (pops - p0 != 4 || fifo_re !== 1'b0) begin
      errs++;
      $display("FAIL bp_pops: pops=%0d fifo_re=%b want 4 0", pops - p0, fifo_re);
    end
    m_ready = 1'b1;
    wait_beats(3, 1'b0, ok, used);
    cmp++;
    if (!ok) begin errs++; $display("FAIL bp_timeout: got %0d beats want 3", got_n - got_rd); end
    for (int b = 0; b < 3; b++) begin
      exp = {16'(2 * b + 2), 16'(2 * b + 1)};
      cmp++;
      if (got_data[got_rd] !== exp || got_keep[got_rd] !== 2'b11 || got_last[got_rd] !== 1'b0) begin
        errs++;
        $display("FAIL bp_beat%0d: got %h/%b/%b want %h/11/0", b, got_data[got_rd], got_keep[got_rd], got_last[got_rd], exp);
      end
      got_rd++;
    end
    cmp++;
    if (hold_bad != 0) begin errs++; $display("FAIL bp_stable: hold violations=%0d want 0", hold_bad); end
  endtask

  task automatic test_flush();
    bit ok;
    int used, p0;
    got_rd = got_n;
    m_ready = 1'b1;
    p0 = pops;
    for (int i = 1; i <= 3; i++) push(16'(i));
    for (int t = 0; t < 50 && pops - p0 < 3; t++) tick();
    cmp++;
    if (pops - p0 != 3) begin errs++; $display("FAIL flush_pops: got %0d want 3", pops - p0); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_beats(2, 1'b0, ok, used);
    cmp++;
    if (got_data[got_rd] !== 32'h0002_0001 || got_keep[got_rd] !== 2'b11 || got_last[got_rd] !== 1'b0) begin
      errs++;
      $display("FAIL flush_full: got %h/%b/%b want 00020001/11/0", got_data[got_rd], got_keep[got_rd], got_last[got_rd]);
    end
    got_rd++;
    cmp++;
    if (got_data[got_rd] !== 32'h0000_0003 || got_keep[got_rd] !== 2'b01 || got_last[got_rd] !== 1'b1) begin
      errs++;
      $display("FAIL flush_partial: got %h/%b/%b want 00000003/01/1", got_data[got_rd], got_keep[got_rd], got_last[got_rd]);
    end
    got_rd++;
    for (int t = 0; t < 50 && busy; t++) tick();
    cmp++;
    if (busy !== 1'b0) begin errs++; $display("FAIL flush_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_underflow();
    bit ok;
    int used;
    got_rd = got_n;
    m_ready = 1'b1;
    fifo_under = 1'b1;
    tick();
    fifo_under = 1'b0;
    cmp++;
    if (err_under !== 1'b1) begin errs++; $display("FAIL under_set: got %b want 1", err_under); end
    push(16'd9);
    push(16'd10);
    wait_beats(1, 1'b0, ok, used);
    cmp++;
    if (got_data[got_rd] !== 32'h000a_0009 || got_keep[got_rd] !== 2'b11 || got_last[got_rd] !== 1'b0) begin
      errs++;
      $display("FAIL under_data: got %h/%b/%b want 000a0009/11/0", got_data[got_rd], got_keep[got_rd], got_last[got_rd]);
    end
    got_rd++;
    repeat (5) tick();
    cmp++;
    if (err_under !== 1'b1) begin errs++; $display("FAIL under_sticky: got %b want 1", err_under); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int used, p0;
    got_rd = got_n;
    m_ready = 1'b1;
    p0 = pops;
    push(16'd5);
    for (int t = 0; t < 50 && pops - p0 < 1; t++) tick();
    tick();
    cmp++;
    if (busy !== 1'b1) begin errs++; $display("FAIL mid_captured: busy=%b want 1", busy); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cmp++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || err_under !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: busy=%b m_valid=%b err_under=%b want 0 0 0", busy, m_valid, err_under);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    cmp++;
    if (got_n != got_rd) begin errs++; $display("FAIL mid_no_beat: got %0d beats want 0", got_n - got_rd); end
    push(16'd7);
    push(16'd8);
    wait_beats(1, 1'b0, ok, used);
    cmp++;
    if (got_data[got_rd] !== 32'h0008_0007 || got_keep[got_rd] !== 2'b11 || got_last[got_rd] !== 1'b0) begin
      errs++;
      $display("FAIL mid_next: got %h/%b/%b want 00080007/11/0", got_data[got_rd], got_keep[got_rd], got_last[got_rd]);
    end
    got_rd++;
  endtask

  task automatic test_random();
    bit ok;
    int used, n, nb, idle;
    logic [DW-1:0] w [0:7];
    logic [N*DW-1:0] ed;
    logic [N-1:0] ek;
    logic el;
    got_rd = got_n;
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        w[i] = 16'($urandom);
        push(w[i]);
        m_ready = 1'($urandom);
        repeat ($urandom_range(0, 2)) begin tick(); m_ready = 1'($urandom); end
      end
      idle = 0;
      for (int t = 0; t < 200 && idle < 3; t++) begin
        tick();
        m_ready = 1'($urandom);
        idle = (fifo_empty && !fifo_re) ? idle + 1 : 0;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      nb = (n + N - 1) / N;
      wait_beats(nb, 1'b1, ok, used);
      cmp++;
      if (!ok) begin errs++; $display("FAIL rand_timeout round %0d: got %0d beats want %0d", r, got_n - got_rd, nb); end
      for (int b = 0; b < nb; b++) begin
        ed = '0;
        ek = '0;
        for (int k = 0; k < N; k++)
          if (b * N + k < n) begin
            ed[k*DW +: DW] = w[b * N + k];
            ek[k] = 1'b1;
          end
        el = (n % N != 0) && b == nb - 1;
        cmp++;
        if (got_data[got_rd] !== ed || got_keep[got_rd] !== ek || got_last[got_rd] !== el) begin
          errs++;
          $display("FAIL rand_beat r%0d b%0d: got %h/%b/%b want %h/%b/%b", r, b, got_data[got_rd], got_keep[got_rd], got_last[got_rd], ed, ek, el);
        end
        got_rd++;
      end
      repeat (4) begin m_ready = 1'($urandom); tick(); end
    end
    m_ready = 1'b1;
    repeat (10) tick();
    cmp++;
    if (got_n != got_rd || busy !== 1'b0) begin
      errs++;
      $display("FAIL rand_extra: extra beats=%0d busy=%b want 0 0", got_n - got_rd, busy);
    end
    cmp++;
    if (re_bad != 0 || hold_bad != 0) begin
      errs++;
      $display("FAIL rand_protocol: re_when_empty=%0d hold_violations=%0d want 0 0", re_bad, hold_bad);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
